// File: rtl/velocity_ring_accum.sv
// Force-fragment ring with per-cell read-modify-write velocity accumulators.
// Optional RING_ACCUM_SAT_EN: saturating component adds (default build wraps modulo 2^COMP_W).
module velocity_ring_accum #(
  parameter int unsigned N_CELL = 27,
  parameter int unsigned CELL_W = 5,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned COMP_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CELL-1:0]          frag_valid,
  output logic [N_CELL-1:0]          frag_ready,
  input  logic [N_CELL*CELL_W-1:0]   frag_cell,
  input  logic [N_CELL*ADDR_W-1:0]   frag_addr,
  input  logic [N_CELL*3*COMP_W-1:0] frag_data,
  output logic [N_CELL*ADDR_W-1:0]   rd_addr,
  input  logic [N_CELL*3*COMP_W-1:0] rd_data,
  output logic [N_CELL-1:0]          wr_en,
  output logic [N_CELL*ADDR_W-1:0]   wr_addr,
  output logic [N_CELL*3*COMP_W-1:0] wr_data,
  output logic                       bad_cell,
  output logic                       drained
);
  localparam int unsigned VecW = 3 * COMP_W;
  localparam logic [CELL_W:0] NCellId = (CELL_W + 1)'(N_CELL);

  logic [N_CELL-1:0]             slot_valid_q, slot_valid_d;
  logic [N_CELL-1:0][CELL_W-1:0] slot_cell_q, slot_cell_d;
  logic [N_CELL-1:0][ADDR_W-1:0] slot_addr_q, slot_addr_d;
  logic [N_CELL-1:0][VecW-1:0]   slot_data_q, slot_data_d;
  logic [N_CELL-1:0]             acc_take, s1_busy, bad_hit;
  logic                          bad_cell_q, drained_q;

`ifdef RING_ACCUM_SAT_EN
  function automatic logic [VecW-1:0] vec_add(input logic [VecW-1:0] a,
                                               input logic [VecW-1:0] b);
    logic [COMP_W:0]   s;
    logic [VecW-1:0]   r;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      s = {a[c*COMP_W+COMP_W-1], a[c*COMP_W +: COMP_W]} +
          {b[c*COMP_W+COMP_W-1], b[c*COMP_W +: COMP_W]};
      // Sign disagreement between the guard bit and MSB means overflow; clamp toward it.
      if (s[COMP_W] != s[COMP_W-1]) r[c*COMP_W +: COMP_W] = {s[COMP_W], {(COMP_W-1){~s[COMP_W]}}};
      else                          r[c*COMP_W +: COMP_W] = s[COMP_W-1:0];
    end
    return r;
  endfunction
`else
  function automatic logic [VecW-1:0] vec_add(input logic [VecW-1:0] a,
                                               input logic [VecW-1:0] b);
    logic [VecW-1:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      r[c*COMP_W +: COMP_W] = a[c*COMP_W +: COMP_W] + b[c*COMP_W +: COMP_W];
    end
    return r;
  endfunction
`endif

  for (genvar i = 0; i < N_CELL; i++) begin : g_node
    localparam int unsigned       Prev = (i + N_CELL - 1) % N_CELL;
    localparam logic [CELL_W-1:0] Self = CELL_W'(i);

    logic [CELL_W-1:0] in_cell, nc;
    logic [ADDR_W-1:0] in_addr, na, aa;
    logic [VecW-1:0]   in_data, nd, ad;
    logic              in_bad, nv, av, rdy, bad;

    assign in_cell = frag_cell[i*CELL_W +: CELL_W];
    assign in_addr = frag_addr[i*ADDR_W +: ADDR_W];
    assign in_data = frag_data[i*VecW +: VecW];
    assign in_bad  = {1'b0, in_cell} >= NCellId;

    always_comb begin
      nv  = 1'b0;
      nc  = slot_cell_q[Prev];
      na  = slot_addr_q[Prev];
      nd  = slot_data_q[Prev];
      av  = 1'b0;
      aa  = slot_addr_q[Prev];
      ad  = slot_data_q[Prev];
      rdy = 1'b0;
      bad = 1'b0;
      if (slot_valid_q[Prev] && slot_cell_q[Prev] != Self) begin
        nv = 1'b1;
      end else begin
        av = slot_valid_q[Prev];
        if (frag_valid[i]) begin
          if (in_bad) begin
            rdy = 1'b1;
            bad = 1'b1;
          end else if (in_cell != Self) begin
            rdy = 1'b1;
            nv  = 1'b1;
            nc  = in_cell;
            na  = in_addr;
            nd  = in_data;
          end else if (!slot_valid_q[Prev]) begin
            // Self-destined fragments only bypass the ring when no packet is arriving here.
            rdy = 1'b1;
            av  = 1'b1;
            aa  = in_addr;
            ad  = in_data;
          end
        end
      end
    end

    assign slot_valid_d[i] = nv;
    assign slot_cell_d[i]  = nc;
    assign slot_addr_d[i]  = na;
    assign slot_data_d[i]  = nd;
    assign frag_ready[i]   = rdy;
    assign bad_hit[i]      = bad;
    assign acc_take[i]     = av;

    logic [ADDR_W-1:0] rd_addr_q, s1_addr_q, wr_addr_q, hist_addr_q;
    logic              s1_valid_q, wr_valid_q, hist_valid_q;
    logic [VecW-1:0]   s1_frag_q, wr_data_q, hist_data_q, base, sum;

    // Writes still in the pipe are newer than the cache copy returned by the read-first port.
    always_comb begin
      base = rd_data[i*VecW +: VecW];
      if (wr_valid_q && wr_addr_q == s1_addr_q) begin
        base = wr_data_q;
      end else if (hist_valid_q && hist_addr_q == s1_addr_q) begin
        base = hist_data_q;
      end
      sum = vec_add(base, s1_frag_q);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_addr_q    <= '0;
        s1_valid_q   <= 1'b0;
        s1_addr_q    <= '0;
        s1_frag_q    <= '0;
        wr_valid_q   <= 1'b0;
        wr_addr_q    <= '0;
        wr_data_q    <= '0;
        hist_valid_q <= 1'b0;
        hist_addr_q  <= '0;
        hist_data_q  <= '0;
      end else begin
        s1_valid_q   <= av;
        if (av) begin
          rd_addr_q <= aa;
          s1_addr_q <= aa;
          s1_frag_q <= ad;
        end
        wr_valid_q   <= s1_valid_q;
        if (s1_valid_q) begin
          wr_addr_q <= s1_addr_q;
          wr_data_q <= sum;
        end
        hist_valid_q <= wr_valid_q;
        hist_addr_q  <= wr_addr_q;
        hist_data_q  <= wr_data_q;
      end
    end

    assign rd_addr[i*ADDR_W +: ADDR_W] = av ? aa : rd_addr_q;
    assign s1_busy[i]                  = s1_valid_q;
    assign wr_en[i]                    = wr_valid_q;
    assign wr_addr[i*ADDR_W +: ADDR_W] = wr_addr_q;
    assign wr_data[i*VecW +: VecW]     = wr_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_valid_q <= '0;
      slot_cell_q  <= '0;
      slot_addr_q  <= '0;
      slot_data_q  <= '0;
      bad_cell_q   <= 1'b0;
      drained_q    <= 1'b1;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_cell_q  <= slot_cell_d;
      slot_addr_q  <= slot_addr_d;
      slot_data_q  <= slot_data_d;
      bad_cell_q   <= bad_cell_q | (|bad_hit);
      // Judged on next-state so drained describes the state registered alongside it.
      drained_q    <= ~|slot_valid_d & ~|frag_valid & ~|acc_take & ~|s1_busy;
    end
  end

  assign bad_cell = bad_cell_q;
  assign drained  = drained_q;

endmodule

// File: tb/tb_velocity_ring_accum.sv
// Directed bench for velocity_ring_accum: 4-cell ring, 16-bit components, read-first cache model.
module tb_velocity_ring_accum;
  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       frag_valid, frag_ready, wr_en;
  logic [3:0][2:0]  fc;
  logic [3:0][3:0]  fa, rd_addr_w, wr_addr_w;
  logic [3:0][47:0] fd, rd_data_w, wr_data_w;
  logic             bad_cell, drained;
  logic [47:0]      mem [4][16];
  int               checks = 0;
  int               errors = 0;

  velocity_ring_accum #(.N_CELL(4), .CELL_W(3), .ADDR_W(4), .COMP_W(16)) dut (
    .clk(clk), .reset(reset), .frag_valid(frag_valid), .frag_ready(frag_ready),
    .frag_cell(fc), .frag_addr(fa), .frag_data(fd), .rd_addr(rd_addr_w), .rd_data(rd_data_w),
    .wr_en(wr_en), .wr_addr(wr_addr_w), .wr_data(wr_data_w), .bad_cell(bad_cell),
    .drained(drained)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      rd_data_w[i] <= mem[i][rd_addr_w[i]];
      if (wr_en[i]) mem[i][wr_addr_w[i]] <= wr_data_w[i];
    end
  end

  function automatic logic [47:0] vec3(input logic [15:0] x, input logic [15:0] y,
                                       input logic [15:0] z);
    return {z, y, x};
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    frag_valid = '0;
    fc = '0;
    fa = '0;
    fd = '0;
  endtask

  task automatic test_reset;
    clear_inputs();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) for (int a = 0; a < 16; a++) mem[c][a] = '0;
    #2;
    checks++; if (wr_en !== 4'b0000) begin errors++; $display("FAIL reset_wr_en got %b exp 0000", wr_en); end
    checks++; if (drained !== 1'b1) begin errors++; $display("FAIL reset_drained got %b exp 1", drained); end
    checks++; if (bad_cell !== 1'b0) begin errors++; $display("FAIL reset_bad_cell got %b exp 0", bad_cell); end
    checks++; if (wr_data_w !== '0) begin errors++; $display("FAIL reset_wr_data got %h exp 0", wr_data_w); end
    repeat (2) next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_direct;
    mem[2][5] = vec3(16'd10, 16'd10, 16'd10);
    next_cycle();
    frag_valid[2] = 1'b1; fc[2] = 3'd2; fa[2] = 4'd5; fd[2] = vec3(16'd1, 16'd2, 16'd3);
    @(negedge clk);
    checks++; if (frag_ready !== 4'b0100) begin errors++; $display("FAIL direct_ready got %b exp 0100", frag_ready); end
    checks++; if (rd_addr_w[2] !== 4'd5) begin errors++; $display("FAIL direct_rd_addr got %0d exp 5", rd_addr_w[2]); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (wr_en !== 4'b0000) begin errors++; $display("FAIL direct_wr_early got %b exp 0000", wr_en); end
    next_cycle();
    @(negedge clk);
    checks++; if (wr_en !== 4'b0100) begin errors++; $display("FAIL direct_wr_en got %b exp 0100", wr_en); end
    checks++; if (wr_addr_w[2] !== 4'd5) begin errors++; $display("FAIL direct_wr_addr got %0d exp 5", wr_addr_w[2]); end
    checks++;
    if (wr_data_w[2] !== vec3(16'd11, 16'd12, 16'd13)) begin
      errors++; $display("FAIL direct_wr_data got %h exp %h", wr_data_w[2], vec3(16'd11, 16'd12, 16'd13));
    end
  endtask

  task automatic test_ring_hop;
    repeat (3) next_cycle();
    frag_valid[0] = 1'b1; fc[0] = 3'd3; fa[0] = 4'd7; fd[0] = vec3(16'd4, 16'd0, 16'd0);
    @(negedge clk);
    checks++; if (frag_ready !== 4'b0001) begin errors++; $display("FAIL hop_ready got %b exp 0001", frag_ready); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (drained !== 1'b0) begin errors++; $display("FAIL hop_busy got %b exp 0", drained); end
    repeat (2) next_cycle();
    @(negedge clk);
    checks++; if (rd_addr_w[3] !== 4'd7) begin errors++; $display("FAIL hop_rd_addr got %0d exp 7", rd_addr_w[3]); end
    checks++; if (wr_en !== 4'b0000) begin errors++; $display("FAIL hop_wr_early got %b exp 0000", wr_en); end
    repeat (2) next_cycle();
    @(negedge clk);
    checks++; if (wr_en !== 4'b1000) begin errors++; $display("FAIL hop_wr_en got %b exp 1000", wr_en); end
    checks++;
    if (wr_data_w[3] !== vec3(16'd4, 16'd0, 16'd0)) begin
      errors++; $display("FAIL hop_wr_data got %h exp %h", wr_data_w[3], vec3(16'd4, 16'd0, 16'd0));
    end
    checks++; if (drained !== 1'b0) begin errors++; $display("FAIL hop_drained_t5 got %b exp 0", drained); end
    next_cycle();
    @(negedge clk);
    checks++; if (drained !== 1'b1) begin errors++; $display("FAIL hop_drained_t6 got %b exp 1", drained); end
  endtask

  task automatic test_back_to_back;
    logic [6:0]  drv, exp_wr;
    logic [15:0] exp_x [7];
    drv    = 7'b0010111;
    exp_wr = 7'b1011100;
    exp_x  = '{16'd0, 16'd0, 16'd101, 16'd102, 16'd103, 16'd0, 16'd104};
    repeat (3) next_cycle();
    mem[1][9] = vec3(16'd100, 16'd0, 16'd0);
    for (int k = 0; k < 7; k++) begin
      next_cycle();
      frag_valid[1] = drv[k]; fc[1] = 3'd1; fa[1] = 4'd9; fd[1] = vec3(16'd1, 16'd0, 16'd0);
      @(negedge clk);
      checks++;
      if (frag_ready !== {2'b00, drv[k], 1'b0}) begin
        errors++; $display("FAIL b2b_ready[%0d] got %b exp %b", k, frag_ready, {2'b00, drv[k], 1'b0});
      end
      checks++;
      if (wr_en !== {2'b00, exp_wr[k], 1'b0}) begin
        errors++; $display("FAIL b2b_wr_en[%0d] got %b exp %b", k, wr_en, {2'b00, exp_wr[k], 1'b0});
      end
      if (exp_wr[k]) begin
        checks++;
        if (wr_data_w[1] !== vec3(exp_x[k], 16'd0, 16'd0)) begin
          errors++; $display("FAIL b2b_wr_data[%0d] got %h exp %h", k, wr_data_w[1],
                             vec3(exp_x[k], 16'd0, 16'd0));
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_contention;
    repeat (3) next_cycle();
    frag_valid[0] = 1'b1; fc[0] = 3'd2; fa[0] = 4'd1; fd[0] = vec3(16'd5, 16'd0, 16'd0);
    @(negedge clk);
    checks++; if (frag_ready !== 4'b0001) begin errors++; $display("FAIL cont_ready_a got %b exp 0001", frag_ready); end
    next_cycle();
    clear_inputs();
    frag_valid[1] = 1'b1; fc[1] = 3'd3; fa[1] = 4'd2; fd[1] = vec3(16'd7, 16'd0, 16'd0);
    @(negedge clk);
    checks++; if (frag_ready !== 4'b0000) begin errors++; $display("FAIL cont_blocked got %b exp 0000", frag_ready); end
    next_cycle();
    @(negedge clk);
    checks++; if (frag_ready !== 4'b0010) begin errors++; $display("FAIL cont_inject got %b exp 0010", frag_ready); end
    next_cycle();
    clear_inputs();
    next_cycle();
    @(negedge clk);
    checks++; if (wr_en !== 4'b0100) begin errors++; $display("FAIL cont_wr_a got %b exp 0100", wr_en); end
    checks++;
    if (wr_data_w[2] !== vec3(16'd5, 16'd0, 16'd0) || wr_addr_w[2] !== 4'd1) begin
      errors++; $display("FAIL cont_data_a got %h@%0d exp %h@1", wr_data_w[2], wr_addr_w[2],
                         vec3(16'd5, 16'd0, 16'd0));
    end
    next_cycle();
    @(negedge clk);
    checks++; if (wr_en !== 4'b0000) begin errors++; $display("FAIL cont_gap got %b exp 0000", wr_en); end
    next_cycle();
    @(negedge clk);
    checks++; if (wr_en !== 4'b1000) begin errors++; $display("FAIL cont_wr_b got %b exp 1000", wr_en); end
    checks++;
    if (wr_data_w[3] !== vec3(16'd7, 16'd0, 16'd0) || wr_addr_w[3] !== 4'd2) begin
      errors++; $display("FAIL cont_data_b got %h@%0d exp %h@2", wr_data_w[3], wr_addr_w[3],
                         vec3(16'd7, 16'd0, 16'd0));
    end
  endtask

  task automatic test_overflow_bad;
    logic [15:0] exp_x;
    logic        saw_wr;
`ifdef RING_ACCUM_SAT_EN
    exp_x = 16'h7FFF;
`else
    exp_x = 16'h8000;
`endif
    repeat (3) next_cycle();
    mem[0][3] = vec3(16'h7FFF, 16'd0, 16'd0);
    frag_valid[0] = 1'b1; fc[0] = 3'd0; fa[0] = 4'd3; fd[0] = vec3(16'd1, 16'd0, 16'd0);
    next_cycle();
    clear_inputs();
    next_cycle();
    @(negedge clk);
    checks++;
    if (wr_en !== 4'b0001 || wr_data_w[0] !== vec3(exp_x, 16'd0, 16'd0)) begin
      errors++; $display("FAIL ovf_wr got en %b data %h exp en 0001 data %h", wr_en, wr_data_w[0],
                         vec3(exp_x, 16'd0, 16'd0));
    end
    next_cycle();
    frag_valid[1] = 1'b1; fc[1] = 3'd6; fa[1] = 4'd0; fd[1] = vec3(16'd9, 16'd9, 16'd9);
    @(negedge clk);
    checks++; if (frag_ready !== 4'b0010) begin errors++; $display("FAIL bad_ready got %b exp 0010", frag_ready); end
    checks++; if (bad_cell !== 1'b0) begin errors++; $display("FAIL bad_early got %b exp 0", bad_cell); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (bad_cell !== 1'b1) begin errors++; $display("FAIL bad_set got %b exp 1", bad_cell); end
    saw_wr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (wr_en !== 4'b0000) saw_wr = 1'b1;
      next_cycle();
      @(negedge clk);
    end
    checks++; if (saw_wr !== 1'b0) begin errors++; $display("FAIL bad_no_write got %b exp 0", saw_wr); end
    checks++; if (bad_cell !== 1'b1) begin errors++; $display("FAIL bad_sticky got %b exp 1", bad_cell); end
  endtask

  task automatic test_reset_midflight;
    logic saw_wr;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      frag_valid[i] = 1'b1; fc[i] = 3'((i + 3) % 4); fa[i] = 4'd11; fd[i] = vec3(16'd1, 16'd1, 16'd1);
    end
    frag_valid[3] = 1'b1; fc[3] = 3'd3; fa[3] = 4'd11; fd[3] = vec3(16'd1, 16'd1, 16'd1);
    @(negedge clk);
    checks++; if (frag_ready !== 4'b1111) begin errors++; $display("FAIL rst_inject got %b exp 1111", frag_ready); end
    next_cycle();
    clear_inputs();
    frag_valid[0] = 1'b1; fc[0] = 3'd2; fa[0] = 4'd11; fd[0] = vec3(16'd1, 16'd1, 16'd1);
    @(negedge clk);
    checks++; if (frag_ready !== 4'b0001) begin errors++; $display("FAIL rst_fifth got %b exp 0001", frag_ready); end
    next_cycle();
    clear_inputs();
    reset = 1'b1;
    #1;
    checks++; if (wr_en !== 4'b0000) begin errors++; $display("FAIL rst_async_wr got %b exp 0000", wr_en); end
    checks++; if (drained !== 1'b1) begin errors++; $display("FAIL rst_async_drained got %b exp 1", drained); end
    checks++; if (bad_cell !== 1'b0) begin errors++; $display("FAIL rst_async_bad got %b exp 0", bad_cell); end
    repeat (2) next_cycle();
    reset = 1'b0;
    saw_wr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (wr_en !== 4'b0000) saw_wr = 1'b1;
      next_cycle();
    end
    checks++; if (saw_wr !== 1'b0) begin errors++; $display("FAIL rst_no_write got %b exp 0", saw_wr); end
    checks++; if (drained !== 1'b1) begin errors++; $display("FAIL rst_drained got %b exp 1", drained); end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_ring_hop();
    test_back_to_back();
    test_contention();
    test_overflow_bad();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
